uart: RTL and testbench

Serial receive block: converts an asynchronous 8N1 line on `info` into parallel bytes on `out`. Sits at a UART pin boundary. Synchronises the line, detects and validates the start bit, and samples eight data bits LSB-first at mid-bit. Presents each correctly framed byte on `out`, which holds until the next good frame or reset.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_sync.sv | 21 ++
 rtl/uart.sv | 94 +++++++++
 tb/tb_uart.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 serial receiver.
`timescale 1ns/1ps
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous receive line; resets to idle level.
`timescale 1ns/1ps
module uart_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= {SYNC_STAGES{IDLE_LEVEL}};
    else      chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/uart.sv
// 8N1 receiver: edge-detected start, mid-bit sampling, byte held on out until next good frame.
`timescale 1ns/1ps
module uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       info,
  output logic [7:0] out
);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  logic                 info_s, prev_s;
  state_t               state;
  logic [15:0]          cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] sr;

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (info),
    .q   (info_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_s  <= IDLE_LEVEL;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
      out     <= '0;
    end else begin
      prev_s <= info_s;
      case (state)
        IDLE: begin
          // Only a true high-to-low transition opens a frame.
          if (prev_s && !info_s) begin
            bit_idx <= '0;
            if (HALF == 16'd0) begin
              state <= DATA;
              cnt   <= '0;
            end else begin
              state <= START;
              cnt   <= 16'd1;
            end
          end
        end
        START: begin
          if (cnt != HALF) begin
            cnt <= cnt + 16'd1;
          end else if (!info_s) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            sr[bit_idx] <= info_s;
            cnt         <= '0;
            bit_idx     <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            // A low stop bit is a framing error: the byte is dropped.
            if (info_s) out <= sr;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: default timing instance plus a 16-clock-per-bit instance.
`timescale 1ns/1ps
module tb_uart;
  logic       clk = 1'b0;
  logic       rst;
  logic       info;
  logic       info16;
  logic [7:0] out;
  logic [7:0] out16;
  int total = 0;
  int bad = 0;

  uart #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .info (info),
    .out  (out)
  );

  uart #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .info (info16),
    .out  (out16)
  );

  always #5 clk = ~clk;

  // Each bit is driven at a negedge and held for n cycles.
  task automatic drive_bits(input logic [9:0] bits, input int n);
    for (int i = 0; i < 10; i++) begin
      info = bits[i];
      repeat (n) @(negedge clk);
    end
  endtask

  task automatic drive16(input logic [9:0] bits);
    for (int i = 0; i < 10; i++) begin
      info16 = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    info = 1'b0;
    info16 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_hold out=%h want=00", out); end
    total++; if (out16 !== 8'h00) begin bad++; $display("FAIL reset_hold16 out=%h want=00", out16); end
    info = 1'b1;
    info16 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_release out=%h want=00", out); end
    total++; if (out16 !== 8'h00) begin bad++; $display("FAIL reset_release16 out=%h want=00", out16); end
  endtask

  task automatic test_single;
    // stop,data[7:0]=A5,start
    drive_bits({1'b1, 8'hA5, 1'b0}, 1);
    info = 1'b1;
    total++; if (out !== 8'h00) begin bad++; $display("FAIL single_t9 out=%h want=00", out); end
    @(negedge clk);
    total++; if (out !== 8'h00) begin bad++; $display("FAIL single_t10 out=%h want=00", out); end
    @(negedge clk);
    total++; if (out !== 8'hA5) begin bad++; $display("FAIL single_t11 out=%h want=A5", out); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_framing;
    drive_bits({1'b0, 8'h3C, 1'b0}, 1);
    // Line stays low after the bad stop bit: no fresh falling edge.
    info = 1'b0;
    repeat (5) @(negedge clk);
    info = 1'b1;
    repeat (15) @(negedge clk);
    total++; if (out !== 8'hA5) begin bad++; $display("FAIL framing_err out=%h want=A5", out); end
    drive_bits({1'b1, 8'h3C, 1'b0}, 1);
    info = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (out !== 8'h3C) begin bad++; $display("FAIL framing_clean out=%h want=3C", out); end
  endtask

  task automatic test_back_to_back;
    logic [19:0] bits;
    bits = {1'b1, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0};
    for (int i = 0; i < 20; i++) begin
      info = bits[i];
      @(negedge clk);
      if (i == 10) begin
        total++; if (out !== 8'h3C) begin bad++; $display("FAIL b2b_t10 out=%h want=3C", out); end
      end
      if (i == 11) begin
        total++; if (out !== 8'hFF) begin bad++; $display("FAIL b2b_t11 out=%h want=FF", out); end
      end
    end
    info = 1'b1;
    @(negedge clk);
    total++; if (out !== 8'hFF) begin bad++; $display("FAIL b2b_t20 out=%h want=FF", out); end
    @(negedge clk);
    total++; if (out !== 8'h01) begin bad++; $display("FAIL b2b_t21 out=%h want=01", out); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    logic [4:0] head;
    head = {4'h3, 1'b0}; // start, then C3 bits 0..3 = 1,1,0,0
    for (int i = 0; i < 5; i++) begin
      info = head[i];
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    total++; if (out !== 8'h00) begin bad++; $display("FAIL midframe_rst out=%h want=00", out); end
    @(negedge clk);
    info = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (out !== 8'h00) begin bad++; $display("FAIL midframe_rel out=%h want=00", out); end
    drive_bits({1'b1, 8'h96, 1'b0}, 1);
    info = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (out !== 8'h96) begin bad++; $display("FAIL midframe_new out=%h want=96", out); end
  endtask

  task automatic test_glitch;
    info16 = 1'b1;
    repeat (4) @(negedge clk);
    info16 = 1'b0;
    repeat (3) @(negedge clk);
    info16 = 1'b1;
    repeat (200) @(negedge clk);
    total++; if (out16 !== 8'h00) begin bad++; $display("FAIL glitch out=%h want=00", out16); end
    drive16({1'b1, 8'h5A, 1'b0});
    info16 = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (out16 !== 8'h5A) begin bad++; $display("FAIL slow_frame out=%h want=5A", out16); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_framing;
    test_back_to_back;
    test_reset_midframe;
    test_glitch;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
